// File: rtl/ads9327_clk_div_gen_pkg.sv
// Shared constants, ratio type and the ratio clamp used by every divider channel.
package ads9327_clk_div_pkg;

  localparam int          DIV_W_DEFAULT = 8;
  localparam int unsigned MIN_DIV       = 2;

  typedef logic [DIV_W_DEFAULT-1:0] div_ratio_t;

  // Ratios 0 and 1 cannot produce a two-phase clock, so they fold to the minimum.
  function automatic int unsigned clamp_ratio(input int unsigned r);
    return (r < MIN_DIV) ? MIN_DIV : r;
  endfunction

endpackage

// File: rtl/ads9327_clk_div_gen_if.sv
// Control/status bundle of the clock divider: run/sync/ratio loads in, divided clocks out.
interface ads9327_clk_div_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
);
  logic                    en;
  logic                    sync;
  logic [NUM_CH*DIV_W-1:0] div_ratio;
  logic [NUM_CH-1:0]       div_load;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       pending;

  modport master (
    output en, sync, div_ratio, div_load,
    input  clk_out, tick, pending
  );

  modport slave (
    input  en, sync, div_ratio, div_load,
    output clk_out, tick, pending
  );
endinterface

// File: rtl/ads9327_clk_div_chan.sv
// One divider channel: shadow/active ratio pair, period counter and registered clk/tick/pending.
module ads9327_clk_div_chan
  import ads9327_clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic [DIV_W-1:0] i_ratio,
  input  logic             i_load,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_pending
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(clamp_ratio(DEFAULT_DIV));

  logic [DIV_W-1:0] r_count, r_active, r_shadow;
  logic             r_pending, r_run, r_clk_out, r_tick;

  logic [DIV_W-1:0] w_ld_val, w_half, w_term, w_cnt_inc;
  logic [DIV_W:0]   w_np1;
  logic [DIV_W-1:0] w_nx_count, w_nx_active, w_nx_shadow;
  logic             w_nx_pending, w_nx_run, w_nx_clk, w_nx_tick;

  assign w_ld_val  = DIV_W'(clamp_ratio(32'(i_ratio)));
  assign w_np1     = {1'b0, r_active} + (DIV_W+1)'(1);
  assign w_half    = w_np1[DIV_W:1];
  assign w_term    = r_active - DIV_W'(1);
  assign w_cnt_inc = r_count + DIV_W'(1);

  always_comb begin
    w_nx_count   = r_count;
    w_nx_active  = r_active;
    w_nx_shadow  = r_shadow;
    w_nx_pending = r_pending;
    w_nx_run     = r_run;
    w_nx_clk     = r_clk_out;
    w_nx_tick    = 1'b0;

    if (i_load) begin
      w_nx_shadow  = w_ld_val;
      w_nx_pending = 1'b1;
    end

    if (!i_en) begin
      w_nx_count = '0;
      w_nx_clk   = 1'b0;
      w_nx_run   = 1'b0;
    end else if (i_sync) begin
      // A load coincident with sync bypasses the shadow and applies at once.
      w_nx_active  = i_load ? w_ld_val : r_shadow;
      w_nx_pending = 1'b0;
      w_nx_count   = '0;
      w_nx_clk     = 1'b1;
      w_nx_tick    = 1'b1;
      w_nx_run     = 1'b1;
    end else if (!r_run || (r_count == w_term)) begin
      // Period boundary: the wrap takes the shadow as it stood before any same-cycle load.
      if (r_pending) w_nx_active = r_shadow;
      w_nx_pending = i_load;
      w_nx_count   = '0;
      w_nx_clk     = 1'b1;
      w_nx_tick    = 1'b1;
      w_nx_run     = 1'b1;
    end else begin
      w_nx_count = w_cnt_inc;
      w_nx_clk   = (w_cnt_inc < w_half);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_active  <= RST_DIV;
      r_shadow  <= RST_DIV;
      r_pending <= 1'b0;
      r_run     <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_count   <= w_nx_count;
      r_active  <= w_nx_active;
      r_shadow  <= w_nx_shadow;
      r_pending <= w_nx_pending;
      r_run     <= w_nx_run;
      r_clk_out <= w_nx_clk;
      r_tick    <= w_nx_tick;
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;
  assign o_pending = r_pending;

endmodule

// File: rtl/ads9327_clk_div_gen.sv
// Multi-channel programmable clock/strobe generator; channels share only en and sync.
module ads9327_clk_div_gen
  import ads9327_clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ads9327_clk_div_gen_if.slave  bus
);

  logic [NUM_CH-1:0] w_clk_out, w_tick, w_pending;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ads9327_clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (bus.en),
      .i_sync    (bus.sync),
      .i_ratio   (bus.div_ratio[g*DIV_W +: DIV_W]),
      .i_load    (bus.div_load[g]),
      .o_clk_out (w_clk_out[g]),
      .o_tick    (w_tick[g]),
      .o_pending (w_pending[g])
    );
  end

  assign bus.clk_out = w_clk_out;
  assign bus.tick    = w_tick;
  assign bus.pending = w_pending;

endmodule

// File: tb/tb_ads9327_clk_div_gen.sv
// Directed bench with a period-timing model of every channel checked on each cycle.
module tb_ads9327_clk_div_gen;
  localparam int NC = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ads9327_clk_div_gen_if #(.NUM_CH(NC), .DIV_W(DW)) bus ();

  ads9327_clk_div_gen #(.NUM_CH(NC), .DIV_W(DW), .DEFAULT_DIV(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel is a period of m_n cycles that began at cycle m_start.
  int cyc = 0;
  int m_start [NC];
  int m_n     [NC];
  int m_sh    [NC];
  bit m_pend  [NC];
  bit m_run   = 1'b0;
  bit m_idle  = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_run = 1'b0; m_idle = 1'b1;
      for (int i = 0; i < NC; i++) begin
        m_start[i] = 0; m_n[i] = 2; m_sh[i] = 2; m_pend[i] = 1'b0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < NC; i++) begin
        int f;
        bit ld;
        f  = int'(bus.div_ratio[i*DW +: DW]);
        if (f < 2) f = 2;
        ld = bus.div_load[i];
        if (!bus.en) begin
          if (ld) begin m_sh[i] = f; m_pend[i] = 1'b1; end
        end else if (bus.sync) begin
          if (ld) m_sh[i] = f;
          m_n[i] = m_sh[i]; m_pend[i] = 1'b0; m_start[i] = cyc;
        end else if (!m_run || (cyc - 1 - m_start[i] == m_n[i] - 1)) begin
          if (m_pend[i]) m_n[i] = m_sh[i];
          m_pend[i] = ld;
          if (ld) m_sh[i] = f;
          m_start[i] = cyc;
        end else if (ld) begin
          m_sh[i] = f; m_pend[i] = 1'b1;
        end
      end
      m_run  = bus.en;
      m_idle = !bus.en;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [NC-1:0] e_clk, e_tick, e_pend;
      for (int i = 0; i < NC; i++) begin
        e_clk[i]  = !m_idle && ((cyc - m_start[i]) < (m_n[i] + 1) / 2);
        e_tick[i] = !m_idle && (cyc == m_start[i]);
        e_pend[i] = m_pend[i];
      end
      chk("model_clk_out", 32'(bus.clk_out), 32'(e_clk));
      chk("model_tick",    32'(bus.tick),    32'(e_tick));
      chk("model_pending", 32'(bus.pending), 32'(e_pend));
    end
  end

  task automatic wait_tick(input int ch);
    bit found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.tick[ch]) found = 1'b1;
    end
    chk($sformatf("tick_wait_ch%0d", ch), 32'(found), 32'd1);
  endtask

  // Samples clk_out[ch] now and on the following n-1 falling edges, MSB first.
  task automatic seq(input int ch, input int n, input logic [31:0] exp, input string name);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      v = {v[30:0], bus.clk_out[ch]};
    end
    chk(name, v, exp);
  endtask

  task automatic set_field(input int ch, input int val);
    bus.div_ratio[ch*DW +: DW] = DW'(val);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b1; bus.sync = 1'b0; bus.div_ratio = '0; bus.div_load = '0;
    repeat (3) @(negedge clk);
    chk("rst_clk_out", 32'(bus.clk_out), 32'd0);
    chk("rst_tick",    32'(bus.tick),    32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    #1 rst_n = 1'b1; chk_on = 1'b1;

    // Default ratio 2.
    wait_tick(0);
    seq(0, 4, 32'b1010, "div2_pattern");

    // ch0 -> 5 loaded at count 0: current div-2 period finishes first.
    wait_tick(0);
    #1 set_field(0, 5); bus.div_load = 4'b0001;
    @(negedge clk);
    chk("ch0_pending_set", 32'(bus.pending[0]), 32'd1);
    #1 bus.div_load = '0;
    wait_tick(0);
    chk("ch0_pending_apply", 32'(bus.pending[0]), 32'd0);
    seq(0, 10, 32'b1110011100, "div5_pattern");

    // Clamp: 0 and 1 become 2.
    #1 set_field(1, 0); set_field(2, 1); bus.div_load = 4'b0110;
    @(negedge clk); #1 bus.div_load = '0;
    wait_tick(1);
    seq(1, 4, 32'b1010, "clamp0_pattern");
    wait_tick(2);
    seq(2, 4, 32'b1010, "clamp1_pattern");

    // 4/6/7/3 then sync mid-period.
    #1 set_field(0, 4); set_field(1, 6); set_field(2, 7); set_field(3, 3);
    bus.div_load = 4'b1111;
    @(negedge clk); #1 bus.div_load = '0;
    repeat (3) @(negedge clk);
    #1 bus.sync = 1'b1;
    @(negedge clk);
    chk("sync_tick_all", 32'(bus.tick), 32'hF);
    #1 bus.sync = 1'b0;
    seq(2, 14, 32'b11110001111000, "div7_pattern");

    // ch3 load 8 during the terminal cycle of a ratio-3 period.
    wait_tick(3);
    @(negedge clk); @(negedge clk);
    chk("ch3_terminal_low", 32'(bus.clk_out[3]), 32'd0);
    #1 set_field(3, 8); bus.div_load = 4'b1000;
    @(negedge clk);
    chk("ch3_wrap_tick",    32'(bus.tick[3]),    32'd1);
    chk("ch3_pending_hold", 32'(bus.pending[3]), 32'd1);
    #1 bus.div_load = '0;
    seq(3, 3, 32'b110, "ch3_old_period");
    wait_tick(3);
    chk("ch3_pending_clear", 32'(bus.pending[3]), 32'd0);
    seq(3, 8, 32'b11110000, "div8_pattern");

    // en low for 10 cycles, then high.
    #1 bus.en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("en_low_clk_out", 32'(bus.clk_out), 32'd0);
    end
    #1 bus.en = 1'b1;
    @(negedge clk);
    chk("en_rise_clk_out", 32'(bus.clk_out), 32'hF);
    chk("en_rise_tick",    32'(bus.tick),    32'hF);

    // Asynchronous reset mid-period.
    @(negedge clk); @(negedge clk);
    #1 chk_on = 1'b0; rst_n = 1'b0;
    #1;
    chk("async_rst_clk_out", 32'(bus.clk_out), 32'd0);
    chk("async_rst_tick",    32'(bus.tick),    32'd0);
    chk("async_rst_pending", 32'(bus.pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
